vic_nested: RTL and testbench
=============================

// Module: vic_nested
// PURPOSE
//  Parametrised nested vectored interrupt controller; successor to the fixed single-level VIC.
//  Adds N channels with programmable priority, preemption, and a return-frame stack holding {PC, CCodes, prio}.
//  Redirects IF via o_ctrl/o_iaddr and restores CCodes to EX via o_ccodes_ctrl/o_ccodes on RETI.
//  Registers are written and read from the MA stage through an index/data/we port.
// PARAMETERS
//  NUM_IRQ     16  number of external interrupt lines (1..24)
//  PRIO_W      2   priority field width; larger value = more urgent
//  NEST_DEPTH  4   frame-stack depth (max nested ISRs)
//  VEC_STRIDE  16  byte spacing of vectors: vector = VBASE + idx*VEC_STRIDE
//  IDX_W       6   register index width
// PORTS
//  clk            in   1        core clock
//  rst            in   1        synchronous, active-high reset
//  i_ext          in   NUM_IRQ  peripheral interrupt lines
//  i_pc           in   32       return PC from EX (instruction not yet committed)
//  i_ccodes       in   4        current condition codes from EX
//  i_reti         in   1        RETI decoded in ID
//  i_not_flush    in   1        EX holds a valid, non-flushed instruction
//  i_reg_addr     in   IDX_W    MA register index
//  i_reg_wdata    in   32       MA write data
//  i_reg_we       in   1        MA write strobe
//  o_reg_rdata    out  32       combinational read data at i_reg_addr
//  o_ctrl         out  1        1-cycle redirect pulse to IF mux and branch-unit flush
//  o_iaddr        out  32       redirect target, valid while o_ctrl=1
//  o_ccodes_ctrl  out  1        1-cycle pulse: EX loads o_ccodes
//  o_ccodes       out  4        restored condition codes
//  o_nest         out  $clog2(NEST_DEPTH+1)  current nesting level
// BEHAVIOUR
//  Reset: all outputs 0; CTRL/ENABLE/PENDING/VBASE/PRIO = 0; stack empty; ERR = 0.
//  Register map: 0 CTRL[0]=GIE; 1 ENABLE[NUM_IRQ-1:0]; 2 PENDING (read; write-1-to-clear);
//   3 VBASE; 4 STATUS {ERR[8], active idx[7:3], nest[2:0]} (write ignored); 8+k PRIO of irq k.
//   Unmapped indices read 0.
//  Pending: a rising edge on i_ext[k] (registered previous sample) sets PENDING[k] the next cycle.
//   A same-cycle set and W1C on the same bit: set wins.
//  Arbitration (combinational): candidates = PENDING & ENABLE; select highest PRIO, lowest index on tie.
//  Take condition: GIE & candidate & i_not_flush & !i_reti & stack not full
//   & (stack empty | cand prio > top prio).
//  Take cycle: push {i_pc, i_ccodes, prio, idx}; clear PENDING[idx];
//   next cycle o_ctrl=1, o_iaddr = VBASE + idx*VEC_STRIDE (32-bit wrap).
//  Latency: edge at cycle n -> PENDING at n+1 -> o_ctrl at n+2 minimum.
//  RETI with stack non-empty: pop; next cycle o_ctrl=1, o_iaddr=saved PC,
//   o_ccodes_ctrl=1, o_ccodes=saved CCodes.
//  RETI with stack empty: no pulse, ERR set (sticky until rst).
//  RETI and eligible take in the same cycle: RETI wins; the take is re-evaluated next cycle.
//  Stack full: no take; requests stay pending. ENABLE cleared while pending: bit retained, not taken.
//  Flushed EX (i_not_flush=0): no take that cycle.
//  Reset mid-ISR: stack discarded; no pulses.
// CONFIGURATION
//  VIC_LEVEL_TRIG_EN defined: PENDING[k] = i_ext[k] level, sampled each cycle;
//   W1C has no effect; no edge registers.
//  Not defined: edge-triggered latching as above.
// STRUCTURE
//  vic_pkg: register index constants (VIC_CTRL, VIC_ENABLE, VIC_PENDING, VIC_VBASE,
//   VIC_STATUS, VIC_PRIO0) and frame typedef {pc, ccodes, prio, idx}.
//  Sub-module vic_frame_stack: LIFO of frames with push/pop, full/empty, top;
//   pop has priority over push.
//  Arbiter and register file stay in vic_nested.
// TESTING
//  GIE=1, EN=0x1, PRIO0=1, VBASE=0x100, rise i_ext[0] at cycle 10, i_pc=0x40
//   -> o_ctrl at 12, o_iaddr=0x100, o_nest=1.
//  In ISR0 (prio1): rise irq3 (prio3) -> preempt, o_iaddr=0x130, nest=2;
//   rise irq5 (prio1) -> stays pending, no pulse.
//  RETI twice -> o_iaddr = ISR0 return PC then 0x40, o_ccodes_ctrl pulses restore the saved codes.
//  Simultaneous rise of irq2 and irq4 at equal prio -> irq2 taken first; irq4 follows after RETI.
//  NEST_DEPTH=4 with 5 ascending-prio IRQs -> 4 taken, 5th held pending;
//   RETI on empty stack -> STATUS.ERR=1, no o_ctrl.
//  Assert rst while nest=2 -> next cycle o_nest=0, PENDING=0, outputs 0;
//   W1C PENDING at the same cycle as a new edge -> bit stays set.

Source files
------------

// File: rtl/vic_pkg.sv
// vic_pkg: shared definitions for the nested vectored interrupt controller.
//  - Register index constants for the MA-stage register port.
//  - vic_frame_t: one return frame {pc, ccodes, prio, idx} held on the nest stack.
//    The prio and idx fields are sized for the largest legal configuration
//    (PRIO_W <= 8, NUM_IRQ <= 24). Narrower builds zero-extend into them.
package vic_pkg;

  localparam int VIC_CTRL    = 0;
  localparam int VIC_ENABLE  = 1;
  localparam int VIC_PENDING = 2;
  localparam int VIC_VBASE   = 3;
  localparam int VIC_STATUS  = 4;
  localparam int VIC_PRIO0   = 8;

  localparam int VIC_PRIO_FW = 8;
  localparam int VIC_IDX_FW  = 5;

  typedef struct packed {
    logic [31:0]            pc;
    logic [3:0]             ccodes;
    logic [VIC_PRIO_FW-1:0] prio;
    logic [VIC_IDX_FW-1:0]  idx;
  } vic_frame_t;

endpackage

// File: rtl/vic_frame_stack.sv
// vic_frame_stack: LIFO of interrupt return frames.
// Ports:
//  clk, rst    clock / synchronous active-high reset (empties the stack)
//  push        push push_frame (ignored when full)
//  pop         drop the top frame (ignored when empty); wins over push
//  push_frame  frame to store
//  top         current top frame ('0 when empty)
//  full/empty  occupancy flags
//  count       number of frames held (0..DEPTH)
module vic_frame_stack
  import vic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  vic_frame_t       push_frame,
  output vic_frame_t       top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  vic_frame_t       mem_q [DEPTH];
  vic_frame_t       mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop && !empty) begin
      cnt_d = cnt_q - 1'b1;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == cnt_q) mem_d[i] = push_frame;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Top of stack is the slot just below the fill count.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i + 1) == cnt_q) top = mem_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/vic_nested.sv
// vic_nested: nested vectored interrupt controller with programmable priority,
// preemption and a return-frame stack.
// Ports:
//  clk, rst                    clock / synchronous active-high reset
//  i_ext                       peripheral interrupt lines
//  i_pc, i_ccodes              return PC and condition codes from EX
//  i_reti, i_not_flush         RETI decoded in ID / EX holds a valid instruction
//  i_reg_addr/wdata/we         MA-stage register write port
//  o_reg_rdata                 combinational read data at i_reg_addr
//  o_ctrl, o_iaddr             1-cycle IF redirect pulse and its target
//  o_ccodes_ctrl, o_ccodes     1-cycle CCodes restore pulse and the codes (RETI)
//  o_nest                      current nesting level
// Build option: define VIC_LEVEL_TRIG_EN to make PENDING follow the i_ext
// levels directly (no edge detection, W1C ignored). Default is edge latching.
module vic_nested
  import vic_pkg::*;
#(
  parameter int NUM_IRQ    = 16,
  parameter int PRIO_W     = 2,
  parameter int NEST_DEPTH = 4,
  parameter int VEC_STRIDE = 16,
  parameter int IDX_W      = 6,
  localparam int NEST_W    = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_ext,
  input  logic [31:0]        i_pc,
  input  logic [3:0]         i_ccodes,
  input  logic               i_reti,
  input  logic               i_not_flush,
  input  logic [IDX_W-1:0]   i_reg_addr,
  input  logic [31:0]        i_reg_wdata,
  input  logic               i_reg_we,
  output logic [31:0]        o_reg_rdata,
  output logic               o_ctrl,
  output logic [31:0]        o_iaddr,
  output logic               o_ccodes_ctrl,
  output logic [3:0]         o_ccodes,
  output logic [NEST_W-1:0]  o_nest
);

  // Register file
  logic                            gie_q, gie_d;
  logic [NUM_IRQ-1:0]              enable_q, enable_d;
  logic [NUM_IRQ-1:0]              pending_q, pending_d;
  logic [31:0]                     vbase_q, vbase_d;
  logic [NUM_IRQ-1:0][PRIO_W-1:0]  prio_q, prio_d;
  logic                            err_q, err_d;

  // Registered redirect outputs
  logic        ctrl_q, ctrl_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        cc_ctrl_q, cc_ctrl_d;
  logic [3:0]  ccodes_q, ccodes_d;

  // Arbiter
  logic [NUM_IRQ-1:0]    cand;
  logic                  best_vld;
  logic [VIC_IDX_FW-1:0] best_idx;
  logic [PRIO_W-1:0]     best_prio;
  logic [PRIO_W-1:0]     top_prio;
  logic                  take, reti_ok;

  // Frame stack
  vic_frame_t        stk_top, push_frame;
  logic              stk_full, stk_empty;
  logic [NEST_W-1:0] stk_count;
  logic [31:0]       nest_ext;

`ifndef VIC_LEVEL_TRIG_EN
  logic [NUM_IRQ-1:0] ext_prev_q, ext_prev_d;
  logic [NUM_IRQ-1:0] w1c, clr;
`endif

  vic_frame_stack #(.DEPTH(NEST_DEPTH), .CNT_W(NEST_W)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (take),
    .pop        (reti_ok),
    .push_frame (push_frame),
    .top        (stk_top),
    .full       (stk_full),
    .empty      (stk_empty),
    .count      (stk_count)
  );

  // Highest priority wins; strict '>' keeps the lowest index on a tie.
  always_comb begin
    cand      = pending_q & enable_q;
    best_vld  = 1'b0;
    best_idx  = '0;
    best_prio = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (cand[k] && (!best_vld || prio_q[k] > best_prio)) begin
        best_vld  = 1'b1;
        best_idx  = VIC_IDX_FW'(k);
        best_prio = prio_q[k];
      end
    end
  end

  assign top_prio = stk_top.prio[PRIO_W-1:0];
  assign reti_ok  = i_reti && !stk_empty;

  // RETI blocks the take outright; the request is simply re-arbitrated next cycle.
  assign take = gie_q && best_vld && i_not_flush && !i_reti && !stk_full &&
                (stk_empty || best_prio > top_prio);

  always_comb begin
    push_frame        = '0;
    push_frame.pc     = i_pc;
    push_frame.ccodes = i_ccodes;
    push_frame.prio   = VIC_PRIO_FW'(best_prio);
    push_frame.idx    = best_idx;
  end

  // Redirect / restore pulses, registered so they appear the cycle after the event.
  always_comb begin
    ctrl_d    = 1'b0;
    iaddr_d   = '0;
    cc_ctrl_d = 1'b0;
    ccodes_d  = '0;
    err_d     = err_q | (i_reti & stk_empty);
    if (reti_ok) begin
      ctrl_d    = 1'b1;
      iaddr_d   = stk_top.pc;
      cc_ctrl_d = 1'b1;
      ccodes_d  = stk_top.ccodes;
    end else if (take) begin
      ctrl_d  = 1'b1;
      iaddr_d = vbase_q + 32'(best_idx) * 32'(VEC_STRIDE);
    end
  end

  // Register writes
  always_comb begin
    gie_d    = gie_q;
    enable_d = enable_q;
    vbase_d  = vbase_q;
    prio_d   = prio_q;
`ifndef VIC_LEVEL_TRIG_EN
    w1c      = '0;
`endif
    if (i_reg_we) begin
      case (i_reg_addr)
        IDX_W'(VIC_CTRL):    gie_d    = i_reg_wdata[0];
        IDX_W'(VIC_ENABLE):  enable_d = i_reg_wdata[NUM_IRQ-1:0];
`ifndef VIC_LEVEL_TRIG_EN
        IDX_W'(VIC_PENDING): w1c      = i_reg_wdata[NUM_IRQ-1:0];
`endif
        IDX_W'(VIC_VBASE):   vbase_d  = i_reg_wdata;
        default: ;
      endcase
      for (int k = 0; k < NUM_IRQ; k++)
        if (i_reg_addr == IDX_W'(VIC_PRIO0 + k)) prio_d[k] = i_reg_wdata[PRIO_W-1:0];
    end
  end

  // Pending latch
`ifdef VIC_LEVEL_TRIG_EN
  always_comb pending_d = i_ext;
`else
  // New edges are OR-ed in last so a same-cycle set beats W1C or a take clear.
  always_comb begin
    ext_prev_d = i_ext;
    clr        = w1c;
    for (int k = 0; k < NUM_IRQ; k++)
      if (take && best_idx == VIC_IDX_FW'(k)) clr[k] = 1'b1;
    pending_d = (pending_q & ~clr) | (i_ext & ~ext_prev_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      gie_q      <= 1'b0;
      enable_q   <= '0;
      pending_q  <= '0;
      vbase_q    <= '0;
      prio_q     <= '0;
      err_q      <= 1'b0;
      ctrl_q     <= 1'b0;
      iaddr_q    <= '0;
      cc_ctrl_q  <= 1'b0;
      ccodes_q   <= '0;
`ifndef VIC_LEVEL_TRIG_EN
      ext_prev_q <= '0;
`endif
    end else begin
      gie_q      <= gie_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      vbase_q    <= vbase_d;
      prio_q     <= prio_d;
      err_q      <= err_d;
      ctrl_q     <= ctrl_d;
      iaddr_q    <= iaddr_d;
      cc_ctrl_q  <= cc_ctrl_d;
      ccodes_q   <= ccodes_d;
`ifndef VIC_LEVEL_TRIG_EN
      ext_prev_q <= ext_prev_d;
`endif
    end
  end

  // Read mux
  assign nest_ext = 32'(stk_count);

  always_comb begin
    o_reg_rdata = '0;
    case (i_reg_addr)
      IDX_W'(VIC_CTRL):    o_reg_rdata = {31'b0, gie_q};
      IDX_W'(VIC_ENABLE):  o_reg_rdata = 32'(enable_q);
      IDX_W'(VIC_PENDING): o_reg_rdata = 32'(pending_q);
      IDX_W'(VIC_VBASE):   o_reg_rdata = vbase_q;
      IDX_W'(VIC_STATUS):  o_reg_rdata = {23'b0, err_q, stk_top.idx, nest_ext[2:0]};
      default: ;
    endcase
    for (int k = 0; k < NUM_IRQ; k++)
      if (i_reg_addr == IDX_W'(VIC_PRIO0 + k)) o_reg_rdata = 32'(prio_q[k]);
  end

  assign o_ctrl        = ctrl_q;
  assign o_iaddr       = iaddr_q;
  assign o_ccodes_ctrl = cc_ctrl_q;
  assign o_ccodes      = ccodes_q;
  assign o_nest        = stk_count;

endmodule

// File: tb/tb_vic_nested.sv
module tb_vic_nested;
  localparam int NIRQ = 16, PW = 3, ND = 4, VS = 16, IW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] i_ext;
  logic [31:0]     i_pc;
  logic [3:0]      i_ccodes;
  logic            i_reti, i_not_flush;
  logic [IW-1:0]   i_reg_addr;
  logic [31:0]     i_reg_wdata;
  logic            i_reg_we;
  logic [31:0]     o_reg_rdata;
  logic            o_ctrl;
  logic [31:0]     o_iaddr;
  logic            o_ccodes_ctrl;
  logic [3:0]      o_ccodes;
  logic [2:0]      o_nest;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vic_nested #(.NUM_IRQ(NIRQ), .PRIO_W(PW), .NEST_DEPTH(ND), .VEC_STRIDE(VS), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .i_ext(i_ext), .i_pc(i_pc), .i_ccodes(i_ccodes),
    .i_reti(i_reti), .i_not_flush(i_not_flush), .i_reg_addr(i_reg_addr),
    .i_reg_wdata(i_reg_wdata), .i_reg_we(i_reg_we), .o_reg_rdata(o_reg_rdata),
    .o_ctrl(o_ctrl), .o_iaddr(o_iaddr), .o_ccodes_ctrl(o_ccodes_ctrl),
    .o_ccodes(o_ccodes), .o_nest(o_nest)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reg_wr(input int a, input logic [31:0] d);
    i_reg_addr = IW'(a); i_reg_wdata = d; i_reg_we = 1'b1;
    tick();
    i_reg_we = 1'b0;
  endtask

  task automatic reg_rd(input int a, output logic [31:0] d);
    i_reg_addr = IW'(a); #1; d = o_reg_rdata;
  endtask

  task automatic do_reset();
    i_ext = '0; i_reti = 0; i_not_flush = 1; i_reg_we = 0; i_reg_addr = '0;
    i_reg_wdata = '0; i_pc = '0; i_ccodes = '0;
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [3:0] cc; int prio; int idx; } tb_frame_t;
  tb_frame_t       stk[$];
  bit              m_gie;
  bit [NIRQ-1:0]   m_en, m_pend, m_prev;
  int              m_prio[NIRQ];
  logic [31:0]     m_vbase;
  bit              e_ctrl, e_cc;
  logic [31:0]     e_iaddr;
  logic [3:0]      e_ccodes;

  task automatic model_step();
    bit found = 0; int bi = 0; int bp = 0; tb_frame_t fr;
    e_ctrl = 0; e_cc = 0; e_iaddr = '0; e_ccodes = '0;
    for (int k = 0; k < NIRQ; k++)
      if (m_pend[k] && m_en[k] && (!found || m_prio[k] > bp)) begin
        found = 1; bi = k; bp = m_prio[k];
      end
    if (i_reti) begin
      if (stk.size() > 0) begin
        fr = stk.pop_back();
        e_ctrl = 1; e_iaddr = fr.pc; e_cc = 1; e_ccodes = fr.cc;
      end
    end else if (m_gie && found && i_not_flush && stk.size() < ND &&
                 (stk.size() == 0 || bp > stk[$].prio)) begin
      fr.pc = i_pc; fr.cc = i_ccodes; fr.prio = bp; fr.idx = bi;
      stk.push_back(fr);
      m_pend[bi] = 0;
      e_ctrl = 1; e_iaddr = m_vbase + 32'(bi * VS);
    end
    for (int k = 0; k < NIRQ; k++) if (i_ext[k] && !m_prev[k]) m_pend[k] = 1;
    m_prev = i_ext;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest} !== 41'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest});
    end
    for (int a = 0; a <= 8; a++) begin
      reg_rd(a, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", a, d); end
    end
    reg_wr(5, 32'hFFFF_FFFF);
    reg_rd(5, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    reg_wr(0, 1); reg_wr(1, 32'h1); reg_wr(8, 1); reg_wr(3, 32'h100);
    i_pc = 32'h40; i_ccodes = 4'hA;
    i_ext[0] = 1'b1;
    tick();
    reg_rd(2, d);
    n_checks++;
    if ({o_ctrl, d} !== {1'b0, 32'h1}) begin n_fail++; $display("FAIL basic_pending: got %h expected %h", {o_ctrl, d}, {1'b0, 32'h1}); end
    tick();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'h100, 3'd1}) begin
      n_fail++; $display("FAIL basic_take: got %h expected %h", {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'h100, 3'd1});
    end
    reg_rd(4, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL basic_status: got %h expected 1", d); end
    tick();
    n_checks++;
    if (o_ctrl !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_len: got %b expected 0", o_ctrl); end
  endtask

  task automatic test_preempt();
    logic [31:0] d;
    reg_wr(1, 32'h29); reg_wr(11, 3); reg_wr(13, 1);
    i_pc = 32'h104; i_ccodes = 4'h5;
    i_ext = 16'h0009;
    tick(); tick();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'h130, 3'd2}) begin
      n_fail++; $display("FAIL preempt_take: got %h expected %h", {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'h130, 3'd2});
    end
    reg_rd(4, d);
    n_checks++;
    if (d !== 32'h1A) begin n_fail++; $display("FAIL preempt_status: got %h expected 1a", d); end
    i_pc = 32'h200; i_ccodes = 4'h3;
    i_ext = 16'h0029;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({o_ctrl, o_nest} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL lowprio_held: got %h expected %h", {o_ctrl, o_nest}, {1'b0, 3'd2}); end
    end
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h20) begin n_fail++; $display("FAIL lowprio_pending: got %h expected 20", d); end
    i_reti = 1; tick(); i_reti = 0;
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest} !== {1'b1, 32'h104, 1'b1, 4'h5, 3'd1}) begin
      n_fail++; $display("FAIL reti1: got %h expected %h", {o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest}, {1'b1, 32'h104, 1'b1, 4'h5, 3'd1});
    end
    tick();
    n_checks++;
    if (o_ctrl !== 1'b0) begin n_fail++; $display("FAIL reti1_equal_prio_held: got %b expected 0", o_ctrl); end
    i_pc = 32'h300;
    i_reti = 1; tick(); i_reti = 0;
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest} !== {1'b1, 32'h40, 1'b1, 4'hA, 3'd0}) begin
      n_fail++; $display("FAIL reti2: got %h expected %h", {o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest}, {1'b1, 32'h40, 1'b1, 4'hA, 3'd0});
    end
    tick();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes_ctrl, o_nest} !== {1'b1, 32'h150, 1'b0, 3'd1}) begin
      n_fail++; $display("FAIL deferred_take: got %h expected %h", {o_ctrl, o_iaddr, o_ccodes_ctrl, o_nest}, {1'b1, 32'h150, 1'b0, 3'd1});
    end
    i_reti = 1; tick(); i_reti = 0;
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes, o_nest} !== {1'b1, 32'h300, 4'h3, 3'd0}) begin
      n_fail++; $display("FAIL reti3: got %h expected %h", {o_ctrl, o_iaddr, o_ccodes, o_nest}, {1'b1, 32'h300, 4'h3, 3'd0});
    end
  endtask

  task automatic test_tie();
    logic [31:0] d;
    do_reset();
    reg_wr(0, 1); reg_wr(3, 32'h1000); reg_wr(10, 2); reg_wr(12, 2); reg_wr(1, 32'h14);
    i_pc = 32'h500; i_ccodes = 4'h1;
    i_ext = 16'h0014;
    tick(); tick();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'h1020, 3'd1}) begin
      n_fail++; $display("FAIL tie_first: got %h expected %h", {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'h1020, 3'd1});
    end
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL tie_pending: got %h expected 10", d); end
    tick();
    n_checks++;
    if (o_ctrl !== 1'b0) begin n_fail++; $display("FAIL tie_no_preempt: got %b expected 0", o_ctrl); end
    i_reti = 1; tick(); i_reti = 0;
    n_checks++;
    if ({o_ctrl, o_iaddr, o_ccodes, o_nest} !== {1'b1, 32'h500, 4'h1, 3'd0}) begin
      n_fail++; $display("FAIL tie_reti: got %h expected %h", {o_ctrl, o_iaddr, o_ccodes, o_nest}, {1'b1, 32'h500, 4'h1, 3'd0});
    end
    tick();
    n_checks++;
    if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'h1040, 3'd1}) begin
      n_fail++; $display("FAIL tie_second: got %h expected %h", {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'h1040, 3'd1});
    end
  endtask

  task automatic test_full_err();
    logic [31:0] d;
    do_reset();
    reg_wr(0, 1); reg_wr(1, 32'h1F);
    for (int k = 0; k < 5; k++) reg_wr(8 + k, k);
    for (int k = 0; k < 4; k++) begin
      i_pc = 32'h1000 + 32'(k * 4);
      i_ext[k] = 1'b1;
      tick(); tick();
      n_checks++;
      if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'(k * 16), 3'(k + 1)}) begin
        n_fail++; $display("FAIL full_take%0d: got %h expected %h", k, {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'(k * 16), 3'(k + 1)});
      end
    end
    i_ext[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({o_ctrl, o_nest} !== {1'b0, 3'd4}) begin n_fail++; $display("FAIL full_blocked: got %h expected %h", {o_ctrl, o_nest}, {1'b0, 3'd4}); end
    end
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL full_pending: got %h expected 10", d); end
    reg_wr(1, 32'hF);
    for (int j = 3; j >= 0; j--) begin
      i_reti = 1; tick(); i_reti = 0;
      n_checks++;
      if ({o_ctrl, o_iaddr, o_nest} !== {1'b1, 32'h1000 + 32'(j * 4), 3'(j)}) begin
        n_fail++; $display("FAIL unwind%0d: got %h expected %h", j, {o_ctrl, o_iaddr, o_nest}, {1'b1, 32'h1000 + 32'(j * 4), 3'(j)});
      end
      tick();
      n_checks++;
      if (o_ctrl !== 1'b0) begin n_fail++; $display("FAIL disabled_not_taken: got %b expected 0", o_ctrl); end
    end
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL disabled_retained: got %h expected 10", d); end
    i_reti = 1; tick(); i_reti = 0;
    reg_rd(4, d);
    n_checks++;
    if ({o_ctrl, d} !== {1'b0, 32'h100}) begin n_fail++; $display("FAIL reti_empty_err: got %h expected %h", {o_ctrl, d}, {1'b0, 32'h100}); end
  endtask

  task automatic test_w1c_flush();
    logic [31:0] d;
    do_reset();
    reg_wr(1, 32'h2);
    i_ext[1] = 1'b1; tick(); tick();
    i_ext[1] = 1'b0; tick();
    i_reg_addr = IW'(2); i_reg_wdata = 32'h2; i_reg_we = 1; i_ext[1] = 1'b1;
    tick(); i_reg_we = 0;
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_race: got %h expected 2", d); end
    reg_wr(2, 32'h2);
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h expected 0", d); end
    i_ext[1] = 1'b0; tick();
    i_ext[1] = 1'b1; tick();
    i_not_flush = 0;
    reg_wr(0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_ctrl !== 1'b0) begin n_fail++; $display("FAIL flush_no_take: got %b expected 0", o_ctrl); end
    end
    i_not_flush = 1; tick();
    n_checks++;
    if ({o_ctrl, o_iaddr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL flush_release: got %h expected %h", {o_ctrl, o_iaddr}, {1'b1, 32'h10}); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    do_reset();
    reg_wr(0, 1); reg_wr(1, 32'h3); reg_wr(8, 1); reg_wr(9, 2);
    i_ext[0] = 1'b1; tick(); tick();
    i_ext[1] = 1'b1; tick(); tick();
    n_checks++;
    if (o_nest !== 3'd2) begin n_fail++; $display("FAIL rst_setup_nest: got %0d expected 2", o_nest); end
    i_ext[2] = 1'b1; tick();
    rst = 1; i_reti = 1; i_ext = '0;
    tick();
    rst = 0; i_reti = 0;
    n_checks++;
    if ({o_ctrl, o_ccodes_ctrl, o_nest} !== 5'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {o_ctrl, o_ccodes_ctrl, o_nest}); end
    reg_rd(2, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_mid_pending: got %h expected 0", d); end
    reg_rd(4, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_mid_status: got %h expected 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    do_reset();
    stk.delete(); m_pend = '0; m_prev = '0;
    m_gie = 1; m_en = NIRQ'($urandom) | NIRQ'(1); m_vbase = $urandom & 32'hFFFF_FF00;
    reg_wr(0, 1); reg_wr(1, 32'(m_en)); reg_wr(3, m_vbase);
    for (int k = 0; k < NIRQ; k++) begin
      m_prio[k] = $urandom_range(0, 7);
      reg_wr(8 + k, m_prio[k]);
    end
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) i_ext[$urandom_range(0, NIRQ - 1)] ^= 1'b1;
      i_reti      = ($urandom_range(0, 5) == 0);
      i_not_flush = ($urandom_range(0, 7) != 0);
      i_pc        = $urandom;
      i_ccodes    = 4'($urandom);
      model_step();
      tick();
      got = {o_ctrl, o_ccodes_ctrl, (o_ccodes_ctrl ? o_ccodes : 4'h0), o_nest} ^ (o_ctrl ? o_iaddr : 32'h0);
      exp = {e_ctrl, e_cc, e_ccodes, 3'(stk.size())} ^ e_iaddr;
      n_checks++;
      if ({o_ctrl, o_ccodes_ctrl, (o_ccodes_ctrl ? o_ccodes : 4'h0), o_nest, (o_ctrl ? o_iaddr : 32'h0)} !==
          {e_ctrl, e_cc, e_ccodes, 3'(stk.size()), e_iaddr}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got ctrl=%b iaddr=%h ccc=%b cc=%h nest=%0d expected ctrl=%b iaddr=%h ccc=%b cc=%h nest=%0d (%h/%h)",
                 c, o_ctrl, o_iaddr, o_ccodes_ctrl, o_ccodes, o_nest, e_ctrl, e_iaddr, e_cc, e_ccodes, stk.size(), got, exp);
      end
    end
    i_reti = 0; i_not_flush = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_tie();
    test_full_err();
    test_w1c_flush();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
